// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults, types and port-index helpers for the register file
// Purpose: common widths and types for regfile_mp and its busy table.
// Ports: none (package).
package rf_pkg;

    localparam int XLEN_DFLT = 64;
    localparam int NREG_DFLT = 32;
    localparam int AW_DFLT   = $clog2(NREG_DFLT);

    typedef logic [AW_DFLT-1:0]   reg_idx_t;
    typedef logic [XLEN_DFLT-1:0] xlen_t;

    // Read port numbering: each issue way owns two consecutive ports (rs1, rs2).
    function automatic int portIdx(input int way, input bit isRs2);
        return 2 * way + int'(isRs2);
    endfunction

    function automatic int rs1Port(input int way);
        return portIdx(way, 1'b0);
    endfunction

    function automatic int rs2Port(input int way);
        return portIdx(way, 1'b1);
    endfunction

endpackage

// File: rtl/regfile_busy_table.sv
// rtl/regfile_busy_table.sv - pending-write scoreboard with same-cycle write-back masking
// Purpose: one busy bit per register; set at issue, cleared at write-back, wiped by flush.
// Ports:
//   clk, reset            clock, async active-high reset (clears all busy bits)
//   alloc_en_i/addr_i     per-way destination allocation
//   wb_en_i/wb_addr_i     per-port write-back (clears busy)
//   flush_i               clear every busy bit, suppress allocs this cycle
//   rd_addr_i             per-read-port source register
//   rd_busy_o             combinational operand-pending flag per read port
module regfile_busy_table
    import rf_pkg::*;
#(
    parameter int NREG  = NREG_DFLT,
    parameter int NWAYS = 2,
    parameter int NWB   = 2,
    localparam int AW   = $clog2(NREG),
    localparam int NRP  = 2 * NWAYS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NWAYS-1:0]    alloc_en_i,
    input  logic [NWAYS*AW-1:0] alloc_addr_i,
    input  logic [NWB-1:0]      wb_en_i,
    input  logic [NWB*AW-1:0]   wb_addr_i,
    input  logic                flush_i,
    input  logic [NRP*AW-1:0]   rd_addr_i,
    output logic [NRP-1:0]      rd_busy_o
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busyNext;

    // Applied in increasing priority: wb clear, then alloc set (a fresh producer
    // outranks the completing one), then flush wipes everything.
    always_comb begin
        busyNext = busy;
        for (int w = 0; w < NWB; w++) begin
            if (wb_en_i[w]) busyNext[wb_addr_i[w*AW +: AW]] = 1'b0;
        end
        if (flush_i) begin
            busyNext = '0;
        end else begin
            for (int a = 0; a < NWAYS; a++) begin
                if (alloc_en_i[a]) busyNext[alloc_addr_i[a*AW +: AW]] = 1'b1;
            end
        end
        busyNext[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy <= '0;
        else       busy <= busyNext;
    end

    // A write-back landing this cycle satisfies the operand through the bypass,
    // so it masks the stored busy bit immediately.
    always_comb begin : busyLookup
        logic wbHit;
        rd_busy_o = '0;
        for (int p = 0; p < NRP; p++) begin
            wbHit = 1'b0;
            for (int w = 0; w < NWB; w++) begin
                if (wb_en_i[w] && (wb_addr_i[w*AW +: AW] == rd_addr_i[p*AW +: AW])) wbHit = 1'b1;
            end
            rd_busy_o[p] = busy[rd_addr_i[p*AW +: AW]] & ~wbHit & (rd_addr_i[p*AW +: AW] != '0);
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write-back bypass and busy scoreboard
// Purpose: NWAYS issue ways x 2 registered read ports, NWB write-back ports.
// Ports:
//   clk, reset            clock, async active-high reset (read flops and busy bits)
//   rd_en_i/rd_addr_i     read request and source register per port
//   rd_data_o             registered read data (1-cycle latency, holds when rd_en_i=0)
//   rd_busy_o             combinational operand-pending flag per port
//   alloc_en_i/addr_i     destination allocation per way
//   wb_en_i/addr_i/data_i write-back ports (higher index wins on collision)
//   flush_i               clear all busy bits
module regfile_mp
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DFLT,
    parameter int NREG  = NREG_DFLT,
    parameter int NWAYS = 2,
    parameter int NWB   = 2,
    localparam int AW   = $clog2(NREG),
    localparam int NRP  = 2 * NWAYS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRP-1:0]      rd_en_i,
    input  logic [NRP*AW-1:0]   rd_addr_i,
    output logic [NRP*XLEN-1:0] rd_data_o,
    output logic [NRP-1:0]      rd_busy_o,
    input  logic [NWAYS-1:0]    alloc_en_i,
    input  logic [NWAYS*AW-1:0] alloc_addr_i,
    input  logic [NWB-1:0]      wb_en_i,
    input  logic [NWB*AW-1:0]   wb_addr_i,
    input  logic [NWB*XLEN-1:0] wb_data_i,
    input  logic                flush_i
);

    logic [XLEN-1:0]            regs [NREG];
    logic [NRP-1:0][XLEN-1:0]   readVal;
    logic [NRP-1:0][XLEN-1:0]   rdData;

    // Array is deliberately not reset. Ascending loop makes the highest-index
    // port the last NBA, so it wins a same-register collision.
    always_ff @(posedge clk) begin
        for (int w = 0; w < NWB; w++) begin
            if (wb_en_i[w] && (wb_addr_i[w*AW +: AW] != '0)) begin
                regs[wb_addr_i[w*AW +: AW]] <= wb_data_i[w*XLEN +: XLEN];
            end
        end
    end

    // Bypass: same-cycle write-back beats the array, highest port wins; x0 reads zero.
    always_comb begin
        readVal = '0;
        for (int p = 0; p < NRP; p++) begin
            readVal[p] = regs[rd_addr_i[p*AW +: AW]];
            for (int w = 0; w < NWB; w++) begin
                if (wb_en_i[w] && (wb_addr_i[w*AW +: AW] == rd_addr_i[p*AW +: AW])) begin
                    readVal[p] = wb_data_i[w*XLEN +: XLEN];
                end
            end
            if (rd_addr_i[p*AW +: AW] == '0) readVal[p] = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdData <= '0;
        end else begin
            for (int p = 0; p < NRP; p++) begin
                if (rd_en_i[p]) rdData[p] <= readVal[p];
            end
        end
    end

    assign rd_data_o = rdData;

    regfile_busy_table #(
        .NREG  (NREG),
        .NWAYS (NWAYS),
        .NWB   (NWB)
    ) busyTable (
        .clk          (clk),
        .reset        (reset),
        .alloc_en_i   (alloc_en_i),
        .alloc_addr_i (alloc_addr_i),
        .wb_en_i      (wb_en_i),
        .wb_addr_i    (wb_addr_i),
        .flush_i      (flush_i),
        .rd_addr_i    (rd_addr_i),
        .rd_busy_o    (rd_busy_o)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp against a behavioural model
module tb_regfile_mp;
    import rf_pkg::*;

    localparam int XLEN  = 64;
    localparam int NREG  = 32;
    localparam int NWAYS = 2;
    localparam int NWB   = 2;
    localparam int AW    = 5;
    localparam int NRP   = 4;

    logic                clk;
    logic                reset;
    logic [NRP-1:0]      rdEn;
    logic [NRP*AW-1:0]   rdAddr;
    logic [NRP*XLEN-1:0] rdDataO;
    logic [NRP-1:0]      rdBusyO;
    logic [NWAYS-1:0]    allocEn;
    logic [NWAYS*AW-1:0] allocAddr;
    logic [NWB-1:0]      wbEn;
    logic [NWB*AW-1:0]   wbAddr;
    logic [NWB*XLEN-1:0] wbData;
    logic                flush;

    int nTests = 0;
    int nFail  = 0;

    // Model: architectural contents, pending-producer set, last latched read per port.
    xlen_t mem   [NREG];
    bit    busyM [NREG];
    xlen_t expRd [NRP];

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NWAYS(NWAYS), .NWB(NWB)) dut (
        .clk          (clk),
        .reset        (reset),
        .rd_en_i      (rdEn),
        .rd_addr_i    (rdAddr),
        .rd_data_o    (rdDataO),
        .rd_busy_o    (rdBusyO),
        .alloc_en_i   (allocEn),
        .alloc_addr_i (allocAddr),
        .wb_en_i      (wbEn),
        .wb_addr_i    (wbAddr),
        .wb_data_i    (wbData),
        .flush_i      (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clearIns();
        rdEn = '0; rdAddr = '0; allocEn = '0; allocAddr = '0;
        wbEn = '0; wbAddr = '0; wbData = '0; flush = 1'b0;
    endtask

    task automatic setRd(input int p, input bit en, input int a);
        rdEn[p] = en;
        rdAddr[p*AW +: AW] = AW'(a);
    endtask

    task automatic setWb(input int w, input bit en, input int a, input logic [63:0] d);
        wbEn[w] = en;
        wbAddr[w*AW +: AW] = AW'(a);
        wbData[w*XLEN +: XLEN] = d;
    endtask

    task automatic setAlloc(input int way, input bit en, input int a);
        allocEn[way] = en;
        allocAddr[way*AW +: AW] = AW'(a);
    endtask

    function automatic xlen_t dutRd(input int p);
        return rdDataO[p*XLEN +: XLEN];
    endfunction

    task automatic modelReset();
        for (int p = 0; p < NRP; p++) expRd[p] = '0;
        for (int r = 0; r < NREG; r++) busyM[r] = 1'b0;
    endtask

    // One clock cycle: check combinational busy, advance the model, check read data.
    task automatic step();
        int    a;
        bit    hit;
        xlen_t v;
        #1;
        for (int p = 0; p < NRP; p++) begin
            a = int'(rdAddr[p*AW +: AW]);
            hit = 1'b0;
            for (int w = 0; w < NWB; w++)
                if (wbEn[w] && int'(wbAddr[w*AW +: AW]) == a) hit = 1'b1;
            chk($sformatf("busy_p%0d", p), 64'(rdBusyO[p]), 64'(busyM[a] && !hit && a != 0));
        end
        for (int p = 0; p < NRP; p++) begin
            if (rdEn[p]) begin
                a = int'(rdAddr[p*AW +: AW]);
                v = mem[a];
                for (int w = 0; w < NWB; w++)
                    if (wbEn[w] && int'(wbAddr[w*AW +: AW]) == a) v = wbData[w*XLEN +: XLEN];
                expRd[p] = (a == 0) ? '0 : v;
            end
        end
        for (int w = 0; w < NWB; w++)
            if (wbEn[w] && wbAddr[w*AW +: AW] != 0) mem[wbAddr[w*AW +: AW]] = wbData[w*XLEN +: XLEN];
        if (flush) begin
            for (int r = 0; r < NREG; r++) busyM[r] = 1'b0;
        end else begin
            for (int w = 0; w < NWB; w++) if (wbEn[w]) busyM[wbAddr[w*AW +: AW]] = 1'b0;
            for (int k = 0; k < NWAYS; k++) if (allocEn[k]) busyM[allocAddr[k*AW +: AW]] = 1'b1;
        end
        busyM[0] = 1'b0;
        @(posedge clk);
        #1;
        for (int p = 0; p < NRP; p++) chk($sformatf("rd_p%0d", p), dutRd(p), expRd[p]);
    endtask

    initial begin
        clearIns();
        modelReset();
        reset = 1'b1;
        #12;
        for (int p = 0; p < NRP; p++) begin
            chk($sformatf("rst_rd_p%0d", p), dutRd(p), 64'h0);
            chk($sformatf("rst_busy_p%0d", p), 64'(rdBusyO[p]), 64'h0);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Write x5, read it back one cycle later.
        setWb(0, 1'b1, 5, 64'hDEAD_BEEF);
        step();
        clearIns();
        setRd(rs1Port(0), 1'b1, 5);
        step();
        chk("x5_read", dutRd(0), 64'hDEAD_BEEF);

        // Asynchronous reset mid-cycle clears read flops at once, array survives.
        clearIns();
        #2;
        reset = 1'b1;
        #1;
        for (int p = 0; p < NRP; p++) chk($sformatf("midrst_rd_p%0d", p), dutRd(p), 64'h0);
        modelReset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        setRd(0, 1'b1, 5);
        step();
        chk("x5_after_rst", dutRd(0), 64'hDEAD_BEEF);

        // Same-cycle bypass and write-port collision.
        clearIns();
        setWb(0, 1'b1, 7, 64'h11);
        setRd(3, 1'b1, 7);
        step();
        chk("bypass_x7", dutRd(3), 64'h11);
        clearIns();
        setWb(0, 1'b1, 7, 64'h22);
        setWb(1, 1'b1, 7, 64'h33);
        setRd(3, 1'b1, 7);
        step();
        chk("wb_collide_bypass", dutRd(3), 64'h33);
        clearIns();
        setRd(2, 1'b1, 7);
        step();
        chk("wb_collide_array", dutRd(2), 64'h33);

        // x0 ignores writes and allocs.
        clearIns();
        setWb(0, 1'b1, 0, 64'hFF);
        setAlloc(0, 1'b1, 0);
        setRd(0, 1'b1, 0);
        step();
        clearIns();
        setRd(0, 1'b1, 0);
        #1;
        chk("x0_busy", 64'(rdBusyO[0]), 64'h0);
        step();
        chk("x0_read", dutRd(0), 64'h0);

        // Alloc then write-back: busy next cycle, dropped combinationally on wb.
        clearIns();
        setAlloc(1, 1'b1, 3);
        step();
        clearIns();
        setRd(1, 1'b0, 3);
        #1;
        chk("x3_busy", 64'(rdBusyO[1]), 64'h1);
        step();
        clearIns();
        setWb(0, 1'b1, 3, 64'h44);
        setRd(1, 1'b1, 3);
        #1;
        chk("x3_wb_unbusy", 64'(rdBusyO[1]), 64'h0);
        step();
        chk("x3_data", dutRd(1), 64'h44);

        // Alloc and wb on the same register: bit stays set, data written.
        clearIns();
        setAlloc(0, 1'b1, 9);
        setWb(1, 1'b1, 9, 64'h55);
        step();
        clearIns();
        setRd(0, 1'b1, 9);
        #1;
        chk("x9_still_busy", 64'(rdBusyO[0]), 64'h1);
        step();
        chk("x9_data", dutRd(0), 64'h55);

        // Flush beats a concurrent alloc.
        clearIns();
        flush = 1'b1;
        setAlloc(0, 1'b1, 10);
        step();
        clearIns();
        setRd(0, 1'b0, 9);
        setRd(2, 1'b0, 10);
        #1;
        chk("flush_x9", 64'(rdBusyO[0]), 64'h0);
        chk("flush_x10", 64'(rdBusyO[2]), 64'h0);
        step();

        // Port 1 holds while disabled across a rewrite of x5.
        for (int i = 0; i < 3; i++) begin
            clearIns();
            setRd(1, 1'b0, 5);
            if (i == 0) setWb(0, 1'b1, 5, 64'h66);
            step();
            chk("p1_hold", dutRd(1), 64'h44);
        end
        clearIns();
        setRd(1, 1'b1, 5);
        step();
        chk("p1_reenable", dutRd(1), 64'h66);

        // Fill every register, then random traffic against the model.
        for (int i = 0; i < 16; i++) begin
            clearIns();
            setWb(0, 1'b1, 2 * i + 1, {$urandom, $urandom});
            if (2 * i + 2 < NREG) setWb(1, 1'b1, 2 * i + 2, {$urandom, $urandom});
            step();
        end
        for (int n = 0; n < 400; n++) begin
            clearIns();
            for (int p = 0; p < NRP; p++)
                setRd(p, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
            for (int k = 0; k < NWAYS; k++)
                setAlloc(k, $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)));
            for (int w = 0; w < NWB; w++)
                setWb(w, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), {$urandom, $urandom});
            flush = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
